// File: rtl/clock_time_set_ctrl.sv
// Digital clock timekeeper and SET-mode sequencer (RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN).
// Optional feature: define BLINK_EN to blink the selected field on led while in a SET state.
module clock_time_set_ctrl #(
    parameter int CLK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic [5:0] sw,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic [5:0] led,
    output logic       tick
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam int            PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_btn_s1;
    logic          r_btn_s2;
    logic          r_btn_d;
    logic          r_btn_evt;
    logic [PW-1:0] r_presc;
    logic [4:0]    r_hr;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic [5:0]    r_prev_sw;
    logic          w_tick;
    logic          w_sw_chg;
    logic [5:0]    w_field;

    // Two-flop synchronizer, then a registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_btn_d   <= 1'b0;
            r_btn_evt <= 1'b0;
        end else begin
            r_btn_s1  <= btn_mode;
            r_btn_s2  <= r_btn_s1;
            r_btn_d   <= r_btn_s2;
            r_btn_evt <= r_btn_s2 & ~r_btn_d;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_btn_evt) begin
            case (r_state)
                ST_RUN:     w_state_next = ST_SET_HR;
                ST_SET_HR:  w_state_next = ST_SET_MIN;
                ST_SET_MIN: w_state_next = ST_SET_SEC;
                default:    w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_next;
    end

    assign w_tick   = (r_state == ST_RUN) && (r_presc == PRESC_MAX);
    assign w_sw_chg = (sw != r_prev_sw);

    // Cleared on a mode event too, so SET states always see a zero prescaler
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_RUN || w_tick || r_btn_evt) r_presc <= '0;
        else                                                 r_presc <= r_presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hr      <= 5'd0;
            r_min     <= 6'd0;
            r_sec     <= 6'd0;
            r_prev_sw <= 6'd0;
        end else begin
            if (w_tick) begin
                if (r_sec == 6'd59) begin
                    r_sec <= 6'd0;
                    if (r_min == 6'd59) begin
                        r_min <= 6'd0;
                        r_hr  <= (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end
            // A mode change only re-arms prev_sw; the field is written on the next switch move
            if (r_btn_evt) begin
                r_prev_sw <= sw;
            end else if (r_state != ST_RUN && w_sw_chg) begin
                r_prev_sw <= sw;
                case (r_state)
                    ST_SET_HR:  if (sw <= 6'd23) r_hr  <= sw[4:0];
                    ST_SET_MIN: if (sw <= 6'd59) r_min <= sw;
                    default:    if (sw <= 6'd59) r_sec <= sw;
                endcase
            end
        end
    end

    always_comb begin
        case (r_state)
            ST_SET_HR:  w_field = {1'b0, r_hr};
            ST_SET_MIN: w_field = r_min;
            default:    w_field = r_sec;
        endcase
    end

`ifdef BLINK_EN
    localparam int            BW         = (CLK_DIV / 2 > 1) ? $clog2(CLK_DIV / 2) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(CLK_DIV / 4);

    logic [BW-1:0] r_blink;
    logic          w_blink_on;

    // Restarts on every mode change so a freshly entered SET state shows its value first
    always_ff @(posedge clk) begin
        if (rst || r_btn_evt || r_blink == BLINK_LAST) r_blink <= '0;
        else                                            r_blink <= r_blink + BW'(1);
    end

    assign w_blink_on = (r_blink < BLINK_HALF);
    assign led        = (r_state != ST_RUN && !w_blink_on) ? 6'd0 : w_field;
`else
    assign led = w_field;
`endif

    assign hr   = r_hr;
    assign min  = r_min;
    assign sec  = r_sec;
    assign mode = r_state;
    assign tick = w_tick;

endmodule

// File: tb/tb_clock_time_set_ctrl.sv
// Bench for clock_time_set_ctrl: time-of-day model in total seconds, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clock_time_set_ctrl;

    localparam int CLK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic [5:0] sw = 6'd0;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic [5:0] led;
    logic       tick;

    clock_time_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .sw      (sw),
        .hr      (hr),
        .min     (min),
        .sec     (sec),
        .mode    (mode),
        .led     (led),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    bit chk_en = 1'b0;

    // Model state: time as seconds of the day, button history of the last 4 sampled levels
    int       m_secs = 0;
    int       m_mode = 0;
    int       m_presc = 0;
    int       m_prev = 0;
    int       m_blink = 0;
    bit [3:0] m_hist = 4'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit evt;
        int v;
        if (rst) begin
            m_secs = 0; m_mode = 0; m_presc = 0; m_prev = 0; m_blink = 0; m_hist = 4'b0;
        end else begin
            // a press seen on the pins at edge n-3 becomes the mode event at edge n
            evt = m_hist[2] && !m_hist[3];
            v   = int'(sw);
            if (m_mode == 0) begin
                if (m_presc == CLK_DIV - 1) m_secs = (m_secs + 1) % 86400;
                m_presc = (m_presc == CLK_DIV - 1 || evt) ? 0 : m_presc + 1;
                if (evt) begin m_mode = 1; m_prev = v; end
            end else begin
                m_presc = 0;
                if (evt) begin
                    m_mode = (m_mode + 1) % 4;
                    m_prev = v;
                end else if (v != m_prev) begin
                    m_prev = v;
                    if (m_mode == 1 && v <= 23) m_secs = v * 3600 + m_secs % 3600;
                    if (m_mode == 2 && v <= 59) m_secs = (m_secs / 3600) * 3600 + v * 60 + m_secs % 60;
                    if (m_mode == 3 && v <= 59) m_secs = m_secs - m_secs % 60 + v;
                end
            end
            m_blink = evt ? 0 : (m_blink + 1) % (CLK_DIV / 2);
            m_hist  = {m_hist[2:0], btn_mode};
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin : compare
        int e_field;
        int e_led;
        if (chk_en) begin
            case (m_mode)
                1:       e_field = m_secs / 3600;
                2:       e_field = (m_secs / 60) % 60;
                default: e_field = m_secs % 60;
            endcase
            e_led = e_field;
`ifdef BLINK_EN
            if (m_mode != 0 && m_blink >= CLK_DIV / 4) e_led = 0;
`endif
            check("hr",   int'(hr),   m_secs / 3600);
            check("min",  int'(min),  (m_secs / 60) % 60);
            check("sec",  int'(sec),  m_secs % 60);
            check("mode", int'(mode), m_mode);
            check("led",  int'(led),  e_led);
            check("tick", int'(tick), (m_mode == 0 && m_presc == CLK_DIV - 1) ? 1 : 0);
            if (tick) tick_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge on which mode advances, with the button released
    task automatic press();
        btn_mode = 1'b1;
        step(4);
        btn_mode = 1'b0;
    endtask

    initial begin
`ifdef BLINK_EN
        int exp_led[5] = '{5, 0, 0, 5, 5};
`endif
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tick_cnt = 0;
        check("rst_hr", int'(hr), 0);
        check("rst_min", int'(min), 0);
        check("rst_sec", int'(sec), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_led", int'(led), 0);
        check("rst_tick", int'(tick), 0);

        // one minute of running
        step(8 * 60);
        check("run_ticks", tick_cnt, 60);
        check("run_min", int'(min), 1);
        check("run_sec", int'(sec), 0);
        $display("run 480 cycles: %0d:%0d:%0d ticks=%0d", hr, min, sec, tick_cnt);

        // button latency and field loads
        btn_mode = 1'b1;
        step(3);
        check("btn_lat3", int'(mode), 0);
        step(1);
        check("btn_lat4", int'(mode), 1);
        sw = 6'd17;
        step(1);
        check("set_hr17", int'(hr), 17);
        check("set_led17", int'(led), 17);
        sw = 6'd30;
        step(1);
        check("set_hr_oor", int'(hr), 17);
        step(5);
        check("btn_held", int'(mode), 1);
        btn_mode = 1'b0;
        step(3);
        press();
        step(3);
        press();
        step(3);
        check("to_set_sec", int'(mode), 3);
        check("sec_no_write", int'(sec), 0);
        sw = 6'd45;
        step(1);
        check("set_sec45", int'(sec), 45);
        press();
        check("back_run", int'(mode), 0);
        step(3);
        $display("set hr/sec: %0d:%0d:%0d mode=%0d", hr, min, sec, mode);

        // preload 23:59:59 and watch the day roll over
        press();
        step(3);
        sw = 6'd23;
        step(1);
        check("pre_hr", int'(hr), 23);
        press();
        step(3);
        sw = 6'd59;
        step(1);
        check("pre_min", int'(min), 59);
        press();
        step(3);
        sw = 6'd0;
        step(1);
        sw = 6'd59;
        step(1);
        check("pre_sec", int'(sec), 59);
        press();
        check("pre_run", int'(mode), 0);
        step(7);
        check("roll_tick", int'(tick), 1);
        check("roll_before", int'(sec), 59);
        step(1);
        check("roll_hr", int'(hr), 0);
        check("roll_min", int'(min), 0);
        check("roll_sec", int'(sec), 0);
        $display("rollover: %0d:%0d:%0d", hr, min, sec);

        // mode event and switch change in the same cycle
        press();
        step(3);
        press();
        step(3);
        btn_mode = 1'b1;
        step(3);
        sw = 6'd33;
        step(1);
        check("coll_mode", int'(mode), 3);
        check("coll_min", int'(min), 0);
        btn_mode = 1'b0;
        step(1);
        check("coll_prev_sw", int'(sec), 0);
        step(2);
        $display("collision: mode=%0d min=%0d sec=%0d", mode, min, sec);

        // reset in the middle of setting minutes
        press();
        check("c6_run", int'(mode), 0);
        step(3);
        press();
        step(3);
        press();
        step(3);
        sw = 6'd60;
        step(1);
        check("min_oor", int'(min), 0);
        sw = 6'd12;
        step(1);
        check("min12", int'(min), 12);
        rst = 1'b1;
        sw = 6'd20;
        step(1);
        rst = 1'b0;
        check("mid_rst_mode", int'(mode), 0);
        check("mid_rst_min", int'(min), 0);
        check("mid_rst_hr", int'(hr), 0);
        check("mid_rst_led", int'(led), 0);
        $display("mid-set reset: mode=%0d %0d:%0d:%0d", mode, hr, min, sec);

        // led view of a freshly set hour
        press();
        sw = 6'd5;
        for (int i = 0; i < 5; i++) begin
            step(1);
`ifdef BLINK_EN
            check("blink_led", int'(led), exp_led[i]);
`else
            check("hold_led", int'(led), 5);
`endif
        end
        $display("led after hr=5: %0d", led);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
